// File: rtl/ours_bdg_x2p_v2_pkg.sv
// Shared types and constants for the AXI4-Lite to APB4 bridge.
package ours_bdg_x2p_v2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of a slot index; at least one bit so single-slot builds stay legal.
  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ours_bdg_x2p_v2_dec.sv
// Combinational address decoder: maps a byte address onto one of PERI_NUM
// equally sized APB slots, or flags it as unmapped.
module ours_bdg_x2p_v2_dec
  import ours_bdg_x2p_v2_pkg::*;
#(
  parameter int               PERI_NUM  = 20,
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               SLOT_SZ   = 'h400,
  localparam int              SLOT_W    = slot_w(PERI_NUM)
) (
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [SLOT_W-1:0]   slot_o,
  output logic [PERI_NUM-1:0] sel_o,
  output logic                unmapped_o
);

  // One extra bit keeps the top-of-window bound from wrapping.
  localparam logic [ADDR_W:0] BASE_X = {1'b0, BASE_ADDR};

  always_comb begin
    sel_o  = '0;
    slot_o = '0;
    for (int i = 0; i < PERI_NUM; i++) begin
      logic [ADDR_W:0] lo;
      logic [ADDR_W:0] hi;
      lo = BASE_X + (ADDR_W+1)'(i * SLOT_SZ);
      hi = lo + (ADDR_W+1)'(SLOT_SZ);
      if (({1'b0, addr_i} >= lo) && ({1'b0, addr_i} < hi)) begin
        sel_o[i] = 1'b1;
        slot_o   = SLOT_W'(i);
      end
    end
    unmapped_o = ~|sel_o;
  end

endmodule

// File: rtl/ours_bdg_x2p_v2.sv
// AXI4-Lite to APB4 bridge: one transaction in flight, fair read/write
// arbitration, DECERR on unmapped addresses and an ACCESS-phase watchdog.
module ours_bdg_x2p_v2
  import ours_bdg_x2p_v2_pkg::*;
#(
  parameter int                PERI_NUM   = 20,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                SLOT_SZ    = 'h400,
  parameter int                TMO_CYCLES = 256
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic [2:0]                   s_awprot,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W/8-1:0]          s_wstrb,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  output logic [1:0]                   s_bresp,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic [2:0]                   s_arprot,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic [PERI_NUM-1:0]          m_psel,
  output logic                         m_penable,
  output logic                         m_pwrite,
  output logic [ADDR_W-1:0]            m_paddr,
  output logic [DATA_W-1:0]            m_pwdata,
  output logic [DATA_W/8-1:0]          m_pstrb,
  output logic [2:0]                   m_pprot,
  input  logic [PERI_NUM-1:0]          m_pready,
  input  logic [PERI_NUM*DATA_W-1:0]   m_prdata,
  input  logic [PERI_NUM-1:0]          m_pslverr,
  output logic [1:0]                   dbg_state
);

  localparam int SLOT_W = slot_w(PERI_NUM);
  localparam int CNT_W  = ($clog2(TMO_CYCLES + 1) > 9) ? $clog2(TMO_CYCLES + 1) : 9;

  state_e              state_q;
  logic                last_wr_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          resp_q;

  logic                grant_wr;
  logic                grant_rd;
  logic [ADDR_W-1:0]   dec_addr;
  logic [SLOT_W-1:0]   dec_slot;
  logic [PERI_NUM-1:0] dec_sel;
  logic                dec_unmapped;
  logic                sel_pready;
  logic                sel_pslverr;
  logic [DATA_W-1:0]   sel_prdata;
  logic                tmo_hit;
  logic                resp_done;

  // Handshakes: a beat transfers on a rising edge where valid && ready. The
  // readies are pulsed combinationally only in IDLE on the granting cycle,
  // AW and W together; bvalid/rvalid are held with stable payload until ready.
  assign grant_wr  = (state_q == IDLE) && s_awvalid && s_wvalid && (!s_arvalid || !last_wr_q);
  assign grant_rd  = (state_q == IDLE) && s_arvalid && (!(s_awvalid && s_wvalid) || last_wr_q);
  assign s_awready = grant_wr;
  assign s_wready  = grant_wr;
  assign s_arready = grant_rd;
  assign dec_addr  = grant_wr ? s_awaddr : s_araddr;

  assign s_bresp   = resp_q;
  assign s_rresp   = resp_q;
  assign dbg_state = state_q;
  assign resp_done = (s_bvalid && s_bready) || (s_rvalid && s_rready);
  assign tmo_hit   = (TMO_CYCLES != 0) && (cnt_q == CNT_W'(TMO_CYCLES - 1));

  ours_bdg_x2p_v2_dec #(
    .PERI_NUM  (PERI_NUM),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .SLOT_SZ   (SLOT_SZ)
  ) u_dec (
    .addr_i     (dec_addr),
    .slot_o     (dec_slot),
    .sel_o      (dec_sel),
    .unmapped_o (dec_unmapped)
  );

  // Only the selected slot's response lines are ever looked at.
  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < PERI_NUM; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        sel_pready  = m_pready[i];
        sel_pslverr = m_pslverr[i];
        sel_prdata  = m_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      slot_q    <= '0;
      cnt_q     <= '0;
      resp_q    <= RESP_OKAY;
      m_psel    <= '0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      m_pstrb   <= '0;
      m_pprot   <= '0;
      s_bvalid  <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            last_wr_q <= grant_wr;
            m_pwrite  <= grant_wr;
            m_paddr   <= dec_addr;
            m_pwdata  <= grant_wr ? s_wdata : '0;
            m_pstrb   <= grant_wr ? s_wstrb : '0;
            m_pprot   <= grant_wr ? s_awprot : s_arprot;
            slot_q    <= dec_slot;
            cnt_q     <= '0;
            if (dec_unmapped) begin
              resp_q   <= RESP_DECERR;
              s_rdata  <= '0;
              s_bvalid <= grant_wr;
              s_rvalid <= grant_rd;
              state_q  <= RESP;
            end else begin
              m_psel  <= dec_sel;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          m_penable <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (sel_pready) begin
            m_psel    <= '0;
            m_penable <= 1'b0;
            resp_q    <= sel_pslverr ? RESP_SLVERR : RESP_OKAY;
            s_rdata   <= m_pwrite ? '0 : sel_prdata;
            s_bvalid  <= m_pwrite;
            s_rvalid  <= !m_pwrite;
            state_q   <= RESP;
          end else if (tmo_hit) begin
            m_psel    <= '0;
            m_penable <= 1'b0;
            resp_q    <= RESP_SLVERR;
            s_rdata   <= '0;
            s_bvalid  <= m_pwrite;
            s_rvalid  <= !m_pwrite;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_done) begin
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ours_bdg_x2p_v2.sv
// Bench for the AXI4-Lite to APB4 bridge: directed cases plus randomized
// transactions against a transaction-level model of latency and response.
module tb_ours_bdg_x2p_v2;

  localparam int PERI_NUM = 20;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SLOT_SZ  = 'h400;
  localparam int TMO      = 8;

  logic                       aclk;
  logic                       areset;
  logic                       s_awvalid, s_awready;
  logic [ADDR_W-1:0]          s_awaddr;
  logic [2:0]                 s_awprot;
  logic                       s_wvalid, s_wready;
  logic [DATA_W-1:0]          s_wdata;
  logic [DATA_W/8-1:0]        s_wstrb;
  logic                       s_bvalid, s_bready;
  logic [1:0]                 s_bresp;
  logic                       s_arvalid, s_arready;
  logic [ADDR_W-1:0]          s_araddr;
  logic [2:0]                 s_arprot;
  logic                       s_rvalid, s_rready;
  logic [DATA_W-1:0]          s_rdata;
  logic [1:0]                 s_rresp;
  logic [PERI_NUM-1:0]        m_psel;
  logic                       m_penable, m_pwrite;
  logic [ADDR_W-1:0]          m_paddr;
  logic [DATA_W-1:0]          m_pwdata;
  logic [DATA_W/8-1:0]        m_pstrb;
  logic [2:0]                 m_pprot;
  logic [PERI_NUM-1:0]        m_pready;
  logic [PERI_NUM*DATA_W-1:0] m_prdata;
  logic [PERI_NUM-1:0]        m_pslverr;
  logic [1:0]                 dbg_state;

  ours_bdg_x2p_v2 #(
    .PERI_NUM (PERI_NUM), .ADDR_W (ADDR_W), .DATA_W (DATA_W),
    .BASE_ADDR ('0), .SLOT_SZ (SLOT_SZ), .TMO_CYCLES (TMO)
  ) dut (
    .aclk (aclk), .areset (areset),
    .s_awvalid (s_awvalid), .s_awready (s_awready), .s_awaddr (s_awaddr), .s_awprot (s_awprot),
    .s_wvalid (s_wvalid), .s_wready (s_wready), .s_wdata (s_wdata), .s_wstrb (s_wstrb),
    .s_bvalid (s_bvalid), .s_bready (s_bready), .s_bresp (s_bresp),
    .s_arvalid (s_arvalid), .s_arready (s_arready), .s_araddr (s_araddr), .s_arprot (s_arprot),
    .s_rvalid (s_rvalid), .s_rready (s_rready), .s_rdata (s_rdata), .s_rresp (s_rresp),
    .m_psel (m_psel), .m_penable (m_penable), .m_pwrite (m_pwrite), .m_paddr (m_paddr),
    .m_pwdata (m_pwdata), .m_pstrb (m_pstrb), .m_pprot (m_pprot),
    .m_pready (m_pready), .m_prdata (m_prdata), .m_pslverr (m_pslverr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit last_wr  = 1'b0;   // model arbitration pointer; reset favours write
  int          cur_wait  = 0;
  bit          cur_err   = 1'b0;
  logic [31:0] cur_rdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // ---------------- APB slave model ----------------
  // Unselected slots babble random responses; the selected slot stalls for
  // cur_wait ACCESS cycles and then answers.
  initial begin : apb_slaves
    int acc;
    int s;
    acc = 0;
    m_pready = '0; m_pslverr = '0; m_prdata = '0;
    forever begin
      @(posedge aclk);
      #2;
      for (int i = 0; i < PERI_NUM; i++) begin
        m_pready[i]  = 1'($urandom_range(0, 1));
        m_pslverr[i] = 1'($urandom_range(0, 1));
        m_prdata[i*DATA_W +: DATA_W] = $urandom;
      end
      if (m_penable && (m_psel != 0)) begin
        acc++;
        s = 0;
        for (int i = 0; i < PERI_NUM; i++) if (m_psel[i]) s = i;
        if (acc > cur_wait) begin
          m_pready[s]  = 1'b1;
          m_pslverr[s] = cur_err;
          m_prdata[s*DATA_W +: DATA_W] = cur_rdata;
        end else begin
          m_pready[s] = 1'b0;
        end
      end else begin
        acc = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot, output bit ok);
    int waited;
    tick();
    if (wr) begin
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      s_awaddr = addr; s_wdata = data; s_wstrb = strb; s_awprot = prot;
    end else begin
      s_arvalid = 1'b1; s_araddr = addr; s_arprot = prot;
    end
    #3;
    waited = 0;
    while (!(wr ? (s_awready && s_wready) : s_arready) && waited < 20) begin
      tick(); #3; waited++;
    end
    ok = (waited < 20);
    check("accept", ok, 1);
    if (ok) last_wr = wr;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_awaddr = $urandom; s_araddr = $urandom; s_wdata = $urandom;
    s_wstrb = 4'($urandom); s_awprot = 3'($urandom); s_arprot = 3'($urandom);
    #3;
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input int w,
                        input bit err, input int bdly);
    bit          mapped, tmo, ok, apb_ok, rdy_ok, hold_ok;
    int          acc_n, exp_lat, k, psel_n;
    logic [19:0] exp_sel;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    mapped    = (addr < 32'(PERI_NUM * SLOT_SZ));
    tmo       = mapped && (w >= TMO);
    acc_n     = tmo ? TMO : w + 1;
    exp_lat   = mapped ? 2 + acc_n : 1;
    exp_sel   = mapped ? (20'd1 << (addr / SLOT_SZ)) : 20'd0;
    exp_resp  = !mapped ? 2'b11 : ((tmo || err) ? 2'b10 : 2'b00);
    exp_rdata = (!wr && mapped && !tmo) ? data : 32'd0;
    cur_wait = w; cur_err = err; cur_rdata = data;

    start_req(wr, addr, data, strb, prot, ok);
    if (!ok) return;
    k = 1; psel_n = 0; apb_ok = 1'b1; rdy_ok = 1'b1;
    while (!(s_bvalid || s_rvalid) && k < 40) begin
      if (s_awready || s_wready || s_arready) rdy_ok = 1'b0;
      if (m_psel != 0) begin
        psel_n++;
        if (m_psel !== exp_sel || m_paddr !== addr || m_pwrite !== wr || m_pprot !== prot ||
            m_pstrb !== (wr ? strb : 4'h0) || (wr && m_pwdata !== data) ||
            m_penable !== (psel_n > 1))
          apb_ok = 1'b0;
      end else if (m_penable) begin
        apb_ok = 1'b0;
      end
      tick(); #3; k++;
    end
    if (m_psel != 0 || m_penable) apb_ok = 1'b0;
    check("latency", k, exp_lat);
    check("psel_cycles", psel_n, mapped ? 1 + acc_n : 0);
    check("apb_fields", apb_ok, 1);
    check("ready_idle", rdy_ok, 1);
    check("valid_dir", wr ? {s_bvalid, s_rvalid} : {s_rvalid, s_bvalid}, 2'b10);
    check("resp", wr ? s_bresp : s_rresp, exp_resp);
    if (!wr) check("rdata", s_rdata, exp_rdata);

    hold_ok = 1'b1;
    for (int d = 0; d < bdly; d++) begin
      tick(); #3;
      if (!(wr ? s_bvalid : s_rvalid) || (wr ? s_bresp : s_rresp) !== exp_resp ||
          (!wr && s_rdata !== exp_rdata) || m_psel != 0 || s_awready || s_arready)
        hold_ok = 1'b0;
    end
    check("resp_hold", hold_ok, 1);
    if (wr) s_bready = 1'b1; else s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    #3;
    check("valid_drop", {s_bvalid, s_rvalid}, 2'b00);
  endtask

  // Both directions requested back to back; grants must alternate and a
  // new grant must follow each response handshake by exactly one cycle.
  task automatic arb_test();
    bit exp_wr, drop_next;
    int grants, hs_n, hs_cyc, bhold;
    exp_wr = !last_wr; grants = 0; hs_n = 0; hs_cyc = -1; bhold = 0; drop_next = 1'b0;
    cur_wait = 0; cur_err = 1'b0; cur_rdata = 32'hA5A5_0000;
    tick();
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_awaddr = 32'h0000_0400; s_araddr = 32'h0000_0C00;
    s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_awprot = 3'd0; s_arprot = 3'd0;
    #3;
    for (int c = 0; c < 300 && hs_n < 4; c++) begin
      if (s_awready || s_arready) begin
        check("arb_dir", s_awready, exp_wr);
        check("arb_excl", s_awready && s_arready, 0);
        if (hs_cyc >= 0) check("arb_gap", c - hs_cyc, 1);
        last_wr = exp_wr;
        exp_wr  = !exp_wr;
        grants++;
        if (grants == 4) drop_next = 1'b1;
      end
      if (s_bvalid) begin
        bhold++;
        if (bhold > 5) begin s_bready = 1'b1; hs_cyc = c; hs_n++; end
      end else begin
        bhold = 0;
      end
      if (s_rvalid) begin s_rready = 1'b1; hs_cyc = c; hs_n++; end
      tick();
      s_bready = 1'b0; s_rready = 1'b0;
      if (drop_next) begin
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; drop_next = 1'b0;
      end
      #3;
    end
    check("arb_grants", grants, 4);
    check("arb_resps", hs_n, 4);
  endtask

  task automatic reset_test();
    bit ok, stray;
    int waited;
    cur_wait = 100; cur_err = 1'b0;
    start_req(1'b1, 32'h0000_1400, 32'h1111_2222, 4'hF, 3'd0, ok);
    waited = 0;
    while (!m_penable && waited < 10) begin tick(); #3; waited++; end
    check("rst_reach_access", m_penable, 1);
    tick(); #3;
    tick(); areset = 1'b1;
    tick(); areset = 1'b0;
    #3;
    check("rst_psel", m_psel, 0);
    check("rst_penable", m_penable, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_state", dbg_state, 0);
    last_wr = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(); #3;
      if (s_bvalid || s_rvalid || m_psel != 0) stray = 1'b1;
    end
    check("rst_discard", stray, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit          wr;
    logic [31:0] addr;
    areset = 1'b1;
    s_awvalid = 1'b0; s_awaddr = '0; s_awprot = '0;
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_bready = 1'b0;
    s_arvalid = 1'b0; s_araddr = '0; s_arprot = '0; s_rready = 1'b0;
    repeat (3) tick();
    #3;
    check("reset_psel", m_psel, 0);
    check("reset_penable", m_penable, 0);
    check("reset_valids", {s_bvalid, s_rvalid}, 0);
    check("reset_readies", {s_awready, s_wready, s_arready}, 0);
    check("reset_apb_bus", {m_paddr, m_pwrite, m_pstrb, m_pprot}, 0);
    check("reset_state", dbg_state, 0);
    tick();
    areset = 1'b0;
    #3;

    do_txn(1'b1, 32'h0000_0804, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 0);
    do_txn(1'b0, 32'h0000_0010, 32'h0000_1234, 4'h0, 3'd2, 3, 1'b1, 1);
    do_txn(1'b0, 32'h0000_5000, 32'hCAFE_0001, 4'h0, 3'd0, 0, 1'b0, 0);
    do_txn(1'b1, 32'h0000_5000, 32'hCAFE_0002, 4'h5, 3'd3, 0, 1'b0, 2);
    do_txn(1'b1, 32'h0000_1400, 32'h5555_AAAA, 4'h3, 3'd1, 30, 1'b0, 2);
    do_txn(1'b0, 32'h0000_1404, 32'h7777_8888, 4'h0, 3'd0, 0, 1'b0, 0);
    do_txn(1'b0, 32'h0000_4FFC, 32'h0F0F_0F0F, 4'h0, 3'd4, TMO - 1, 1'b0, 0);
    do_txn(1'b0, 32'h0000_4FFC, 32'h0F0F_0F0F, 4'h0, 3'd4, TMO, 1'b1, 0);

    arb_test();
    reset_test();
    do_txn(1'b0, 32'h0000_2008, 32'h600D_600D, 4'h0, 3'd0, 1, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 2)
        addr = $urandom_range(32'h0000_5000, 32'hFFFF_FFFC) & ~32'h3;
      else
        addr = $urandom_range(0, PERI_NUM - 1) * SLOT_SZ + ($urandom_range(0, 255) << 2);
      do_txn(wr, addr, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
             $urandom_range(0, 10), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
